// File: rtl/alu_mult_seq_if.sv
// Request/response and ALU-side signals of the shift-and-add multiplier sequencer.
// slave is the sequencer's view; master is the requester/ALU side.
interface alu_mult_seq_if #(parameter int instruction_width = 32);
  localparam int W = instruction_width;

  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_ctr;
  logic [W-1:0] alu_y;
  logic         alu_zero;

  modport slave (
    input  start, multiplicand, multiplier, alu_y, alu_zero,
    output busy, done, product_hi, product_lo, alu_a, alu_b, alu_ctr
  );

  modport master (
    output start, multiplicand, multiplier, alu_y, alu_zero,
    input  busy, done, product_hi, product_lo, alu_a, alu_b, alu_ctr
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Multi-cycle unsigned multiplier that uses the external single-cycle ALU
// for its OR-zero test and its W shift-and-add iterations.
//
//   state | meaning
//   IDLE  | waiting for start, ALU driven with zeros
//   CHECK | OR multiplier with 0; zero result takes the early-out path
//   ADD   | one shift-and-add iteration per cycle, W cycles
//   DONE  | product valid, done pulse; start here is accepted directly
module alu_mult_seq #(
  parameter int instruction_width = 32
) (
  input logic          clk,
  input logic          rst,
  alu_mult_seq_if.slave bus
);
  localparam int W  = instruction_width;
  localparam int CW = $clog2(W) + 1;

  localparam logic [3:0] CTR_AND = 4'b0000;
  localparam logic [3:0] CTR_OR  = 4'b0001;
  localparam logic [3:0] CTR_ADD = 4'b0010;

  typedef enum logic [1:0] {IDLE, CHECK, ADD, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  sum;
  logic          c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    count_d     = count_q;
    sum         = hi_q;
    c           = 1'b0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_ctr = CTR_AND;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d = bus.multiplicand;
          lo_d    = bus.multiplier;
          hi_d    = '0;
          count_d = '0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        bus.alu_a   = lo_q;
        bus.alu_ctr = CTR_OR;
        if (bus.alu_zero) begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        bus.alu_a   = hi_q;
        bus.alu_b   = mcand_q;
        bus.alu_ctr = CTR_ADD;
        if (lo_q[0]) begin
          sum = bus.alu_y;
          // carry out of the ALU add, recovered from the operand and result MSBs
          c = (hi_q[W-1] & mcand_q[W-1]) |
              ((hi_q[W-1] | mcand_q[W-1]) & ~bus.alu_y[W-1]);
        end
        hi_d    = {c, sum[W-1:1]};
        lo_d    = {sum[0], lo_q[W-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == CHECK) || (state_q == ADD);
  assign bus.done       = (state_q == DONE);
  assign bus.product_hi = hi_q;
  assign bus.product_lo = lo_q;
endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: ALU model, vector table, scoreboard and corner-case sequences.
module tb_alu_mult_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_mult_seq_if #(.instruction_width(W)) bus ();

  alu_mult_seq #(.instruction_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference single-cycle ALU
  always_comb begin
    case (bus.alu_ctr)
      4'b0000: bus.alu_y = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_y = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_y = bus.alu_a + bus.alu_b;
      default: bus.alu_y = '0;
    endcase
  end
  assign bus.alu_zero = ~|bus.alu_y;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.alu_ctr > 4'd2) begin
        errors++;
        $display("FAIL alu_ctr_legal: got %b, want 0000/0001/0010", bus.alu_ctr);
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } vec_t;

  vec_t            vecs[5];
  logic [2*W-1:0]  sb[$];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic sample_edge();
    @(posedge clk);
    #1;
  endtask

  // waits for done; k counts edges after the accept edge
  task automatic wait_done(input string name, output int k, output bit seen_add);
    k = 0;
    seen_add = 1'b0;
    while (!bus.done && k < 40) begin
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      if (bus.alu_ctr == 4'b0010) seen_add = 1'b1;
      sample_edge();
      k++;
    end
    if (!bus.done) begin
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, want done", name, k);
    end
  endtask

  task automatic pop_check(input string name);
    logic [2*W-1:0] exp;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got empty scoreboard, want an entry", name);
    end else begin
      exp = sb.pop_front();
      chk({name, "_product"}, {bus.product_hi, bus.product_lo}, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int lat, input string name);
    int k;
    bit seen_add;
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    sample_edge();
    bus.start = 1'b0;
    sb.push_back(exp);
    wait_done(name, k, seen_add);
    chk({name, "_latency"}, 64'(k), 64'(lat));
    chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    pop_check(name);
    if (lat == 1) chk({name, "_no_add"}, 64'(seen_add), 64'd0);
    sample_edge();
    chk({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({name, "_hold"}, {bus.product_hi, bus.product_lo}, exp);
  endtask

  initial begin
    int k;
    bit seen_add;
    logic [W-1:0] ra, rb;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0,        lo: 32'd15,       lat: 33};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   hi: 32'hFFFFFFFE, lo: 32'h00000001, lat: 33};
    vecs[2] = '{a: 32'h12345678,   b: 32'h0,          hi: 32'h0,        lo: 32'h0,        lat: 1};
    vecs[3] = '{a: 32'h0,          b: 32'hDEADBEEF,   hi: 32'h0,        lo: 32'h0,        lat: 33};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'h1,          hi: 32'h0,        lo: 32'hFFFFFFFF, lat: 33};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #12;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      sample_edge();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      chk("idle_done", 64'(bus.done), 64'd0);
      chk("idle_product", {bus.product_hi, bus.product_lo}, 64'd0);
      chk("idle_ctr", 64'(bus.alu_ctr), 64'd0);
    end

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'h0 : $urandom;
      run_op(ra, rb, {32'h0, ra} * {32'h0, rb}, (rb == 0) ? 1 : 33, $sformatf("rnd%0d", i));
    end

    // start held through a run, operands changed mid-run, then back-to-back accept in DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier = 32'd9;
    sample_edge();
    bus.multiplicand = 32'hDEADBEEF;
    bus.multiplier = 32'hCAFEF00D;
    sb.push_back(64'd63);
    wait_done("hold", k, seen_add);
    chk("hold_latency", 64'(k), 64'd33);
    pop_check("hold");
    bus.multiplicand = 32'd2;
    bus.multiplier = 32'h80000000;
    sample_edge();
    bus.start = 1'b0;
    sb.push_back(64'h0000000100000000);
    chk("b2b_accept_busy", 64'(bus.busy), 64'd1);
    chk("b2b_no_second_done", 64'(bus.done), 64'd0);
    wait_done("b2b", k, seen_add);
    chk("b2b_latency", 64'(k), 64'd33);
    pop_check("b2b");

    // asynchronous reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'd100;
    bus.multiplier = 32'd200;
    sample_edge();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) sample_edge();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_product", {bus.product_hi, bus.product_lo}, 64'd0);
    chk("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    chk("rst_ctr", 64'(bus.alu_ctr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd100, 32'd200, 64'd20000, 33, "after_rst");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
